pixel_sequencer: RTL and testbench

Frame-level control FSM for the digital pixel sensor, sitting directly upstream of the 8-bit pixel-array counter and the pixel array. It sequences each frame through erase, exposure, conversion and row readout. During conversion it drives the counter's clock and reset so that the ramp code is broadcast to the array. It then steps row selection through a ready handshake with the downstream readout.

---
 rtl/pixel_sequencer_pkg.sv | 28 ++
 rtl/pixel_sequencer_phase_timer.sv | 27 ++
 rtl/pixel_sequencer.sv | 151 +++++++++++++++
 tb/tb_pixel_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sequencer_pkg.sv
// Shared types and constants for the pixel-array frame sequencer.
// COUNTER_W matches the pixel-array ramp counter that this block clocks.
package pixel_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    localparam int ERASE_CYCLES_DEF  = 5;
    localparam int EXPOSE_CYCLES_DEF = 255;
    localparam int CONVERT_STEPS_DEF = 255;
    localparam int ROWS_DEF          = 2;
    localparam int COUNTER_W         = 8;

    // The timer is loaded with length-1, so $clog2 of the longest phase is enough.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pixel_sequencer_phase_timer.sv
// Loadable down-counter that measures the length of each sequencer phase.
// DONE is high while the count sits at zero; the count holds there until reloaded.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic             DONE
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count <= '0;
        end else if (LOAD) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign DONE = (count == '0);

endmodule

// File: rtl/pixel_sequencer.sv
// Frame FSM for the digital pixel sensor: erase, expose, ramp conversion, row readout.
// Every output is a register updated alongside the state, so none follows an input combinationally.
module pixel_sequencer
    import pixel_sequencer_pkg::*;
#(
    parameter int ERASE_CYCLES  = ERASE_CYCLES_DEF,
    parameter int EXPOSE_CYCLES = EXPOSE_CYCLES_DEF,
    parameter int CONVERT_STEPS = CONVERT_STEPS_DEF,
    parameter int ROWS          = ROWS_DEF,
    parameter int ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ROW_READY,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             CONVERT,
    output logic             COUNTER_RESET,
    output logic             COUNTER_CLOCK,
    output logic             READ,
    output logic [ROW_W-1:0] ROW_SELECT,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    if (ERASE_CYCLES < 1 || EXPOSE_CYCLES < 1 || CONVERT_STEPS < 1 ||
        CONVERT_STEPS > (1 << COUNTER_W) - 1 || ROWS < 1 || ROW_W < 1 ||
        (ROWS > 1 && (1 << ROW_W) < ROWS)) begin : g_param_check
        $error("pixel_sequencer: parameter outside its legal range");
    end

    localparam int TIMER_W = timer_width(ERASE_CYCLES, EXPOSE_CYCLES, 2 * CONVERT_STEPS);

    localparam logic [TIMER_W-1:0] ERASE_LOAD   = TIMER_W'(ERASE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] EXPOSE_LOAD  = TIMER_W'(EXPOSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CONVERT_LOAD = TIMER_W'(2 * CONVERT_STEPS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW     = ROW_W'(ROWS - 1);

    state_t               state;
    logic                 timer_load;
    logic                 timer_done;
    logic [TIMER_W-1:0]   timer_value;

    // The timer is loaded on the same edge that enters a timed state.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    timer_load  = 1'b1;
                    timer_value = ERASE_LOAD;
                end
            end
            S_ERASE: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = EXPOSE_LOAD;
                end
            end
            S_EXPOSE: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = CONVERT_LOAD;
                end
            end
            default: ;
        endcase
    end

    phase_timer #(
        .WIDTH(TIMER_W)
    ) u_phase_timer (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .LOAD       (timer_load),
        .LOAD_VALUE (timer_value),
        .DONE       (timer_done)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state         <= S_IDLE;
            ERASE         <= 1'b0;
            EXPOSE        <= 1'b0;
            CONVERT       <= 1'b0;
            READ          <= 1'b0;
            BUSY          <= 1'b0;
            FRAME_DONE    <= 1'b0;
            COUNTER_CLOCK <= 1'b0;
            COUNTER_RESET <= 1'b1;
            ROW_SELECT    <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_ERASE;
                        ERASE <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (timer_done) begin
                        state  <= S_EXPOSE;
                        ERASE  <= 1'b0;
                        EXPOSE <= 1'b1;
                    end
                end
                S_EXPOSE: begin
                    if (timer_done) begin
                        state         <= S_CONVERT;
                        EXPOSE        <= 1'b0;
                        CONVERT       <= 1'b1;
                        COUNTER_RESET <= 1'b0;
                        COUNTER_CLOCK <= 1'b0;
                    end
                end
                // Toggle on all but the last cycle, so the phase ends with the clock high.
                S_CONVERT: begin
                    if (timer_done) begin
                        state         <= S_READ;
                        CONVERT       <= 1'b0;
                        COUNTER_RESET <= 1'b1;
                        COUNTER_CLOCK <= 1'b0;
                        READ          <= 1'b1;
                        ROW_SELECT    <= '0;
                    end else begin
                        COUNTER_CLOCK <= ~COUNTER_CLOCK;
                    end
                end
                S_READ: begin
                    if (ROW_READY) begin
                        if (ROW_SELECT == LAST_ROW) begin
                            state      <= S_IDLE;
                            READ       <= 1'b0;
                            BUSY       <= 1'b0;
                            FRAME_DONE <= 1'b1;
                            ROW_SELECT <= '0;
                        end else begin
                            ROW_SELECT <= ROW_SELECT + ROW_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Scoreboard bench for pixel_sequencer: a default instance and a minimum-parameter instance.
// Stimulus queues expected phase lengths, row indices and output snapshots; a negedge monitor compares.
module tb_pixel_sequencer;

    localparam int NT        = 10;
    localparam int T_ERASE   = 0;
    localparam int T_EXPOSE  = 1;
    localparam int T_CONVERT = 2;
    localparam int T_READ    = 3;
    localparam int T_DONE    = 4;
    localparam int T_CNT     = 5;
    localparam int T_EDGES   = 6;
    localparam int T_ROW     = 7;
    localparam int T_GAP     = 8;
    localparam int T_SNAP    = 9;

    // Snapshot word {ERASE,EXPOSE,CONVERT,READ,BUSY,FRAME_DONE,COUNTER_CLOCK,COUNTER_RESET,ROW_SELECT}
    localparam int SNAP_IDLE       = 2;
    localparam int SNAP_ERASE      = 274;
    localparam int SNAP_DONE       = 10;
    localparam int SNAP_READ_ROW1  = 51;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] start = 2'b00;
    logic [1:0] row_ready = 2'b00;
    logic [1:0] erase, expose, convert, rd, fdone, cclk, crst, busy, rsel;

    int checks = 0;
    int errors = 0;
    int exp_q [2*NT][$];
    int snap_req [2];
    int snap_done [2];

    int len [2][5];
    bit [4:0] prev [2];
    bit prev_cclk [2];
    int cnt [2];
    int conv_cnt [2];
    int edges [2];
    int since [2] = '{-1, -1};

    always #5 clk = ~clk;

    pixel_sequencer u_dut (
        .CLOCK         (clk),
        .RESET         (rst[0]),
        .START         (start[0]),
        .ROW_READY     (row_ready[0]),
        .ERASE         (erase[0]),
        .EXPOSE        (expose[0]),
        .CONVERT       (convert[0]),
        .COUNTER_RESET (crst[0]),
        .COUNTER_CLOCK (cclk[0]),
        .READ          (rd[0]),
        .ROW_SELECT    (rsel[0:0]),
        .BUSY          (busy[0]),
        .FRAME_DONE    (fdone[0])
    );

    pixel_sequencer #(
        .ERASE_CYCLES  (1),
        .EXPOSE_CYCLES (1),
        .CONVERT_STEPS (1),
        .ROWS          (1)
    ) u_dut_min (
        .CLOCK         (clk),
        .RESET         (rst[1]),
        .START         (start[1]),
        .ROW_READY     (row_ready[1]),
        .ERASE         (erase[1]),
        .EXPOSE        (expose[1]),
        .CONVERT       (convert[1]),
        .COUNTER_RESET (crst[1]),
        .COUNTER_CLOCK (cclk[1]),
        .READ          (rd[1]),
        .ROW_SELECT    (rsel[1:1]),
        .BUSY          (busy[1]),
        .FRAME_DONE    (fdone[1])
    );

    function automatic string tag_name(input int t);
        case (t)
            T_ERASE:   return "erase_len";
            T_EXPOSE:  return "expose_len";
            T_CONVERT: return "convert_len";
            T_READ:    return "read_len";
            T_DONE:    return "frame_done_len";
            T_CNT:     return "counter_model";
            T_EDGES:   return "counter_edges";
            T_ROW:     return "row_select";
            T_GAP:     return "restart_gap";
            default:   return "snapshot";
        endcase
    endfunction

    function automatic bit sig_of(input int i, input int w);
        case (w)
            T_ERASE:   return erase[i];
            T_EXPOSE:  return expose[i];
            T_CONVERT: return convert[i];
            T_READ:    return rd[i];
            default:   return fdone[i];
        endcase
    endfunction

    task automatic observe(input int i, input int tag, input int val);
        int e;
        checks++;
        if (exp_q[i*NT+tag].size() == 0) begin
            errors++;
            $display("FAIL dut%0d %s: observed %0d, nothing expected", i, tag_name(tag), val);
        end else begin
            e = exp_q[i*NT+tag].pop_front();
            if (e != val) begin
                errors++;
                $display("FAIL dut%0d %s: observed %0d, expected %0d", i, tag_name(tag), val, e);
            end
        end
    endtask

    task automatic mon(input int i);
        bit [4:0] s;
        s = {fdone[i], rd[i], convert[i], expose[i], erase[i]};
        if (crst[i]) cnt[i] = 0;
        else if (cclk[i] && !prev_cclk[i]) cnt[i]++;
        if (convert[i]) begin
            if (cclk[i] && !prev_cclk[i]) edges[i]++;
            conv_cnt[i] = cnt[i];
        end
        if (rst[i]) begin
            for (int k = 0; k < 5; k++) len[i][k] = 0;
            edges[i] = 0;
            since[i] = -1;
        end else begin
            if (rd[i] && row_ready[i]) observe(i, T_ROW, int'(rsel[i]));
            for (int k = 0; k < 5; k++) begin
                if (s[k]) begin
                    len[i][k]++;
                end else if (len[i][k] > 0) begin
                    observe(i, k, len[i][k]);
                    if (k == T_CONVERT) begin
                        observe(i, T_CNT, conv_cnt[i]);
                        observe(i, T_EDGES, edges[i]);
                        edges[i] = 0;
                    end
                    len[i][k] = 0;
                end
            end
            // Restart gap counted from the edge that registers FRAME_DONE.
            if (s[4] && !prev[i][4]) since[i] = 1;
            else if (since[i] >= 0) since[i]++;
            if (s[0] && !prev[i][0] && since[i] >= 0) begin
                observe(i, T_GAP, since[i]);
                since[i] = -1;
            end
            if (since[i] > 4) since[i] = -1;
        end
        prev_cclk[i] = cclk[i];
        prev[i] = s;
        if (snap_req[i] != snap_done[i]) begin
            observe(i, T_SNAP, int'({erase[i], expose[i], convert[i], rd[i], busy[i],
                                     fdone[i], cclk[i], crst[i], rsel[i]}));
            snap_done[i]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int tag, input int val);
        exp_q[i*NT+tag].push_back(val);
    endtask

    task automatic snap(input int i, input int val);
        push(i, T_SNAP, val);
        snap_req[i]++;
    endtask

    task automatic push_frame(input int i, input int e, input int x, input int c,
                              input int rows, input int read_len);
        push(i, T_ERASE, e);
        push(i, T_EXPOSE, x);
        push(i, T_CONVERT, 2 * c);
        push(i, T_CNT, c);
        push(i, T_EDGES, c);
        for (int r = 0; r < rows; r++) push(i, T_ROW, r);
        push(i, T_READ, read_len);
        push(i, T_DONE, 1);
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        cyc(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_hi(input int i, input int which, input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            cyc(1);
            seen = sig_of(i, which);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dut%0d wait_%s: stayed low for %0d cycles, required high", i, tag_name(which), limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state on both instances
        cyc(2);
        snap(0, SNAP_IDLE);
        snap(1, SNAP_IDLE);
        rst = 2'b00;
        cyc(3);

        // Nominal frame, ROW_READY tied high
        row_ready[0] = 1'b1;
        push_frame(0, 5, 255, 255, 2, 2);
        pulse_start(0);
        snap(0, SNAP_ERASE);
        wait_hi(0, T_DONE, 3000);
        snap(0, SNAP_DONE);
        cyc(10);

        // Readout backpressure: 7 cycles not ready then one ready, twice
        row_ready[0] = 1'b0;
        push_frame(0, 5, 255, 255, 2, 16);
        pulse_start(0);
        wait_hi(0, T_READ, 3000);
        cyc(7);
        row_ready[0] = 1'b1;
        cyc(1);
        row_ready[0] = 1'b0;
        snap(0, SNAP_READ_ROW1);
        cyc(7);
        row_ready[0] = 1'b1;
        cyc(1);
        row_ready[0] = 1'b0;
        cyc(10);

        // START pulsed during exposure is neither taken nor queued
        row_ready[0] = 1'b1;
        push_frame(0, 5, 255, 255, 2, 2);
        pulse_start(0);
        wait_hi(0, T_EXPOSE, 100);
        cyc(10);
        pulse_start(0);
        wait_hi(0, T_DONE, 3000);
        cyc(20);
        snap(0, SNAP_IDLE);
        cyc(10);

        // START held: back-to-back frames with a single idle cycle
        push_frame(0, 5, 255, 255, 2, 2);
        push(0, T_GAP, 2);
        push_frame(0, 5, 255, 255, 2, 2);
        start[0] = 1'b1;
        wait_hi(0, T_DONE, 3000);
        cyc(2);
        start[0] = 1'b0;
        wait_hi(0, T_DONE, 3000);
        cyc(10);

        // Reset held two cycles in the middle of conversion
        push(0, T_ERASE, 5);
        push(0, T_EXPOSE, 255);
        pulse_start(0);
        wait_hi(0, T_CONVERT, 1000);
        cyc(20);
        rst[0] = 1'b1;
        cyc(1);
        snap(0, SNAP_IDLE);
        cyc(1);
        rst[0] = 1'b0;
        cyc(5);

        // RESET and START on the same edge
        rst[0] = 1'b1;
        start[0] = 1'b1;
        cyc(1);
        snap(0, SNAP_IDLE);
        rst[0] = 1'b0;
        start[0] = 1'b0;
        cyc(3);
        snap(0, SNAP_IDLE);
        cyc(5);

        // RESET on the accepting edge of the last row suppresses FRAME_DONE
        row_ready[0] = 1'b0;
        push(0, T_ERASE, 5);
        push(0, T_EXPOSE, 255);
        push(0, T_CONVERT, 510);
        push(0, T_CNT, 255);
        push(0, T_EDGES, 255);
        push(0, T_ROW, 0);
        pulse_start(0);
        wait_hi(0, T_READ, 3000);
        row_ready[0] = 1'b1;
        cyc(1);
        rst[0] = 1'b1;
        cyc(1);
        snap(0, SNAP_IDLE);
        cyc(1);
        rst[0] = 1'b0;
        row_ready[0] = 1'b0;
        cyc(5);

        // Minimum parameters: one cycle each, a single ramp edge, one row
        row_ready[1] = 1'b1;
        push_frame(1, 1, 1, 1, 1, 1);
        pulse_start(1);
        wait_hi(1, T_DONE, 50);
        snap(1, SNAP_DONE);
        cyc(10);

        for (int q = 0; q < 2*NT; q++) begin
            while (exp_q[q].size() > 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d %s: expected %0d, never observed", q / NT, tag_name(q % NT),
                         exp_q[q].pop_front());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
